// File: rtl/onchip_mem_arbiter.sv
// Two-requester round-robin Avalon-MM arbiter in front of a single-port on-chip RAM.
// Screens out-of-range word addresses and returns tagged read data after a fixed latency.
module onchip_mem_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int MEM_DEPTH   = 40000,
  parameter int MEM_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic [15:0]         oor_count
);
  localparam int BE_W = DATA_W/8;
  localparam int L    = MEM_LATENCY;
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_DEPTH);

  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wd;
  } req_t;

  req_t [1:0]              w_req;
  req_t                    w_win;
  logic [1:0]              w_act, w_gnt;
  logic                    w_any, w_id, w_oor, w_is_rd, w_cs;
  logic                    r_run, r_pref;
  logic [L:0]              r_vld_pipe, r_id_pipe;
  logic [L-1:0]            r_oor_pipe;
  logic [1:0][DATA_W-1:0]  r_rdata;
  logic [15:0]             r_oor_cnt;

  assign w_req[0] = {m0_read, m0_write, m0_address, m0_byteenable, m0_writedata};
  assign w_req[1] = {m1_read, m1_write, m1_address, m1_byteenable, m1_writedata};
  assign w_act    = {w_req[1].rd | w_req[1].wr, w_req[0].rd | w_req[0].wr};

  // r_pref names the requester that wins a tie; it flips away from every winner
  assign w_gnt[0] = r_run & w_act[0] & (~w_act[1] | ~r_pref);
  assign w_gnt[1] = r_run & w_act[1] & (~w_act[0] |  r_pref);
  assign w_any    = |w_gnt;
  assign w_id     = w_gnt[1];
  assign w_win    = w_req[w_id];
  assign w_oor    = {1'b0, w_win.addr} >= LIMIT;
  assign w_is_rd  = w_win.rd & ~w_win.wr;
  assign w_cs     = w_any & ~w_oor;

  assign m0_waitrequest = ~w_gnt[0];
  assign m1_waitrequest = ~w_gnt[1];

  assign mem_chipselect = w_cs;
  assign mem_write      = w_cs & w_win.wr;
  assign mem_address    = w_cs ? w_win.addr : '0;
  assign mem_byteenable = w_cs ? w_win.be   : '0;
  assign mem_writedata  = w_cs ? w_win.wd   : '0;
  assign mem_clken      = r_run;
  assign oor_count      = r_oor_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run     <= 1'b0;
      r_pref    <= 1'b0;
      r_oor_cnt <= '0;
    end else begin
      r_run <= 1'b1;
      if (w_any) r_pref <= ~w_id;
      if (w_any && w_oor && r_oor_cnt != 16'hFFFF) r_oor_cnt <= r_oor_cnt + 16'd1;
    end
  end

  // Tag stages 0..L-1 track the RAM access; stage L is the output strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld_pipe <= '0;
      r_id_pipe  <= '0;
      r_oor_pipe <= '0;
    end else begin
      r_vld_pipe[0] <= w_any & w_is_rd;
      r_id_pipe[0]  <= w_id;
      r_oor_pipe[0] <= w_oor;
      for (int i = 1; i <= L; i++) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
        r_id_pipe[i]  <= r_id_pipe[i-1];
      end
      for (int i = 1; i < L; i++) r_oor_pipe[i] <= r_oor_pipe[i-1];
    end
  end

  for (genvar k = 0; k < 2; k++) begin : g_rsp
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
        r_rdata[k] <= '0;
      else if (r_vld_pipe[L-1] && r_id_pipe[L-1] == 1'(k))
        r_rdata[k] <= r_oor_pipe[L-1] ? '0 : mem_readdata;
    end
  end

  assign m0_readdata      = r_rdata[0];
  assign m1_readdata      = r_rdata[1];
  assign m0_readdatavalid = r_vld_pipe[L] & ~r_id_pipe[L];
  assign m1_readdatavalid = r_vld_pipe[L] &  r_id_pipe[L];
endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Random and directed stimulus for onchip_mem_arbiter, checked against a transaction-level
// model: ideal memory, round-robin rule and a due-cycle queue of expected read returns.
module tb_onchip_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] m0_address = '0, m1_address = '0;
  logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
  logic [31:0] m0_writedata = '0, m1_writedata = '0;
  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata;
  logic [15:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata, mem_readdata;
  logic [15:0] oor_count;

  always #5 clk = ~clk;

  onchip_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .oor_count(oor_count)
  );

  // RAM behind the arbiter: one-cycle read latency, byte-lane writes
  bit [31:0] ram [0:65535];
  bit [31:0] ram_q;
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        ram_q <= ram[mem_address];
      end
    end
  end
  assign mem_readdata = ram_q;

  typedef struct { bit act; bit rd; bit wr; logic [15:0] a; logic [3:0] be; logic [31:0] wd; } pend_t;
  typedef struct { int due; logic [31:0] d; } rsp_t;

  pend_t       pd [2];
  bit [31:0]   gold [0:65535];
  rsp_t        rq0[$], rq1[$];
  int          pref_m, oor_m, cyc, n_vec, n_err;
  logic [31:0] last0, last1;
  bit          rnd_en;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic bit [31:0] merge(input bit [31:0] old, input logic [3:0] be, input logic [31:0] wd);
    bit [31:0] n = old;
    for (int b = 0; b < 4; b++) if (be[b]) n[8*b +: 8] = wd[8*b +: 8];
    return n;
  endfunction

  function automatic pend_t rand_req();
    pend_t p;
    int kind = $urandom_range(2);
    int sel  = $urandom_range(9);
    p.act = 1'b1;
    p.rd  = (kind != 1);
    p.wr  = (kind != 0);
    if (sel < 7)       p.a = 16'($urandom_range(31));
    else if (sel == 7) p.a = 16'(39998 + $urandom_range(3));
    else if (sel == 8) p.a = 16'hFFFF;
    else               p.a = 16'($urandom_range(65535));
    p.be = 4'($urandom_range(15));
    p.wd = $urandom;
    return p;
  endfunction

  function automatic pend_t mk(input bit rd, input bit wr, input logic [15:0] a,
                               input logic [3:0] be, input logic [31:0] wd);
    pend_t p;
    p.act = 1'b1; p.rd = rd; p.wr = wr; p.a = a; p.be = be; p.wd = wd;
    return p;
  endfunction

  // One bus cycle: drive held requests, check everything at the falling edge, advance the model
  task automatic step();
    int g;
    bit r0, r1, v0, v1, oor;
    logic [15:0] a;
    m0_read = pd[0].act & pd[0].rd;  m0_write = pd[0].act & pd[0].wr;
    m0_address = pd[0].a; m0_byteenable = pd[0].be; m0_writedata = pd[0].wd;
    m1_read = pd[1].act & pd[1].rd;  m1_write = pd[1].act & pd[1].wr;
    m1_address = pd[1].a; m1_byteenable = pd[1].be; m1_writedata = pd[1].wd;
    @(negedge clk);
    cyc++;
    r0 = pd[0].act; r1 = pd[1].act;
    g = -1;
    if (r0 && r1) g = pref_m;
    else if (r0)  g = 0;
    else if (r1)  g = 1;
    chk("wait0", 32'(m0_waitrequest), 32'(g != 0));
    chk("wait1", 32'(m1_waitrequest), 32'(g != 1));
    chk("clken", 32'(mem_clken), 32'(1));
    chk("oor_count", 32'(oor_count), 32'(oor_m));
    v0 = rq0.size() > 0 && rq0[0].due == cyc;
    v1 = rq1.size() > 0 && rq1[0].due == cyc;
    chk("rdv0", 32'(m0_readdatavalid), 32'(v0));
    chk("rdv1", 32'(m1_readdatavalid), 32'(v1));
    if (v0) begin last0 = rq0[0].d; void'(rq0.pop_front()); end
    if (v1) begin last1 = rq1[0].d; void'(rq1.pop_front()); end
    chk("rdata0", m0_readdata, last0);
    chk("rdata1", m1_readdata, last1);
    if (g >= 0) begin
      a   = pd[g].a;
      oor = 32'(a) >= 40000;
      chk("chipselect", 32'(mem_chipselect), 32'(!oor));
      if (!oor) chk("mem_address", 32'(mem_address), 32'(a));
      if (pd[g].wr) begin
        chk("mem_write", 32'(mem_write), 32'(!oor));
        if (!oor) gold[a] = merge(gold[a], pd[g].be, pd[g].wd);
      end else begin
        chk("mem_write", 32'(mem_write), 32'(0));
        if (g == 0) rq0.push_back('{cyc + 2, oor ? 32'h0 : gold[a]});
        else        rq1.push_back('{cyc + 2, oor ? 32'h0 : gold[a]});
      end
      if (oor && oor_m < 65535) oor_m++;
      pref_m = 1 - g;
      pd[g].act = 1'b0;
    end else begin
      chk("chipselect_idle", 32'(mem_chipselect), 32'(0));
    end
    if (rnd_en)
      for (int k = 0; k < 2; k++)
        if (!pd[k].act && $urandom_range(3) != 0) pd[k] = rand_req();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int m, input pend_t p);
    pd[m] = p;
    for (int i = 0; i < 10 && pd[m].act; i++) step();
    chk("grant_timeout", 32'(pd[m].act), 32'(0));
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Reset with both requesters asserting reads: all outputs must sit at reset values
  task automatic do_reset();
    reset_n = 1'b0;
    pd[0].act = 1'b0; pd[1].act = 1'b0;
    m0_read = 1'b1; m1_read = 1'b1; m0_write = 1'b0; m1_write = 1'b0;
    rq0.delete(); rq1.delete();
    pref_m = 0; oor_m = 0; last0 = '0; last1 = '0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_wait0", 32'(m0_waitrequest), 32'(1));
      chk("rst_wait1", 32'(m1_waitrequest), 32'(1));
      chk("rst_rdv", 32'({m0_readdatavalid, m1_readdatavalid}), 32'(0));
      chk("rst_rdata0", m0_readdata, 32'h0);
      chk("rst_rdata1", m1_readdata, 32'h0);
      chk("rst_oor", 32'(oor_count), 32'(0));
      chk("rst_clken", 32'(mem_clken), 32'(0));
      chk("rst_cs", 32'({mem_chipselect, mem_write}), 32'(0));
    end
    m0_read = 1'b0; m1_read = 1'b0;
    reset_n = 1'b1;
    drain(2);
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0; rnd_en = 1'b0;
    pd[0] = '{default: '0}; pd[1] = '{default: '0};
    do_reset();

    // write then read back through m0
    issue(0, mk(1'b0, 1'b1, 16'h0010, 4'hF, 32'hDEADBEEF));
    issue(0, mk(1'b1, 1'b0, 16'h0010, 4'h0, 32'h0));
    drain(3);
    chk("t1_readback", m0_readdata, 32'hDEADBEEF);

    // continuous reads from both: alternating grants, per-port returns
    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < 2; k++)
        if (!pd[k].act) pd[k] = mk(1'b1, 1'b0, 16'($urandom_range(31)), 4'h0, 32'h0);
      step();
    end
    pd[0].act = 1'b0; pd[1].act = 1'b0;
    drain(3);

    // byte-lane merge through m1
    issue(1, mk(1'b0, 1'b1, 16'h0020, 4'hF, 32'h11223344));
    issue(1, mk(1'b0, 1'b1, 16'h0020, 4'h2, 32'h0000AA00));
    issue(1, mk(1'b1, 1'b0, 16'h0020, 4'h0, 32'h0));
    drain(3);
    chk("t3_merge", m1_readdata, 32'h1122AA44);

    // out-of-range write and read
    issue(0, mk(1'b0, 1'b1, 16'd40000, 4'hF, 32'hCAFEF00D));
    issue(0, mk(1'b1, 1'b0, 16'd40000, 4'h0, 32'h0));
    drain(3);
    chk("t4_oor_rdata", m0_readdata, 32'h0);
    chk("t4_oor_count", 32'(oor_count), 32'(2));

    // read and write together is a write
    issue(0, mk(1'b1, 1'b1, 16'h0005, 4'hF, 32'h5A5A5A5A));
    drain(3);
    chk("t5_ram", ram[16'h0005], 32'h5A5A5A5A);

    // reset one cycle after an m1 read grant: its return must vanish
    issue(1, mk(1'b1, 1'b0, 16'h0010, 4'h0, 32'h0));
    do_reset();
    drain(2);
    pd[0] = mk(1'b1, 1'b0, 16'h0001, 4'h0, 32'h0);
    pd[1] = mk(1'b1, 1'b0, 16'h0002, 4'h0, 32'h0);
    step();
    chk("t6_first_grant_m1_still_pending", 32'(pd[1].act), 32'(1));
    drain(4);

    // random traffic
    rnd_en = 1'b1;
    drain(400);
    rnd_en = 1'b0;
    pd[0].act = 1'b0; pd[1].act = 1'b0;
    drain(3);

    // saturate the out-of-range counter with back-to-back dropped writes
    for (int i = 0; i < 65600; i++) begin
      for (int k = 0; k < 2; k++)
        if (!pd[k].act) pd[k] = mk(1'b0, 1'b1, 16'hFFF0, 4'hF, 32'h1);
      step();
    end
    pd[0].act = 1'b0; pd[1].act = 1'b0;
    drain(2);
    chk("t4_oor_sat", 32'(oor_count), 32'h0000FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
- Two-requester Avalon-MM arbiter that shares the single-port 32-bit on-chip RAM (16-bit word address, 4-bit byteenable, one-cycle read latency) between the ADC sample writer (m0) and the HPS/Nios bridge (m1).
- Performs round-robin grant, drives the RAM port, and returns read data with a fixed latency tagged to the issuing requester.
- Screens out-of-range addresses and counts them.

Parameters:
- ADDR_W, 16, word-address width of requesters and RAM port.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- MEM_DEPTH, 40000, number of valid words; addresses >= MEM_DEPTH are out of range.
- MEM_LATENCY, 1, RAM read latency in cycles from address sample to mem_readdata valid.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- m0_address, m1_address  in  ADDR_W  requester word address
- m0_read, m1_read  in  1  read request
- m0_write, m1_write  in  1  write request
- m0_byteenable, m1_byteenable  in  DATA_W/8  byte lanes
- m0_writedata, m1_writedata  in  DATA_W  write data
- m0_waitrequest, m1_waitrequest  out  1  request not accepted this cycle
- m0_readdata, m1_readdata  out  DATA_W  returned read data
- m0_readdatavalid, m1_readdatavalid  out  1  read data valid strobe
- mem_address  out  ADDR_W  RAM address
- mem_byteenable  out  DATA_W/8  RAM byte lanes
- mem_chipselect  out  1  RAM select
- mem_write  out  1  RAM write enable
- mem_writedata  out  DATA_W  RAM write data
- mem_clken  out  1  RAM clock enable
- mem_readdata  in  DATA_W  RAM read data
- oor_count  out  16  saturating count of out-of-range accesses

Behaviour:
- Clock and reset: one clock, clk. Reset is reset_n, asynchronous assert, active-low; deassertion is synchronised externally.
- Reset values:
  - waitrequest outputs 1.
  - readdatavalid outputs 0; readdata outputs 0.
  - oor_count 0; mem_clken 0.
  - Round-robin pointer prefers m0.
  - Read tag pipeline cleared.
- Out of reset: mem_clken = 1 constantly.
- Request: mN_req = mN_read | mN_write. If both read and write are asserted, the request is treated as a write.
- Arbitration (combinational, cycle N):
  - Only one requester active: it is granted.
  - Both active: the requester not granted most recently wins.
  - Pointer updates at the clock edge on each grant.
  - Starvation bound: a continuously requesting master waits at most 1 cycle.
- Grant cycle N:
  - Winner's waitrequest = 0; loser's waitrequest = 1.
  - An idle requester sees waitrequest = 1. Requesters must hold signals until waitrequest = 0.
- RAM drive (combinational in cycle N from the winner): mem_address, mem_byteenable, mem_writedata, mem_write = winner write.
  - mem_chipselect = 1 only for an in-range grant; otherwise all mem_* control signals are 0.
- Out-of-range (address >= MEM_DEPTH):
  - Still granted (waitrequest 0) and counted: oor_count increments, saturating at 16'hFFFF.
  - Write is dropped.
  - Read returns readdata = 0 with readdatavalid at normal latency.
- Read return:
  - Tag {valid, id, oor} enters a shift pipeline of depth MEM_LATENCY+1.
  - mem_readdata is registered into mN_readdata, with mN_readdatavalid = 1 for exactly one cycle in cycle N+MEM_LATENCY+1 (N+2 at default).
  - The other requester's readdatavalid stays 0 that cycle.
  - readdata holds its last value when not valid.
- Throughput: one access per cycle; back-to-back reads from alternating requesters return in issue order, one per cycle.
- Writes produce no response.
- Reset mid-operation: in-flight tags are discarded; no readdatavalid after reset even if a read was granted the cycle before.

Test Plan:
- Reset, then m0 writes 32'hDEADBEEF, byteenable 4'hF to addr 16'h0010; m0 then reads 16'h0010 -> waitrequest 0 on each grant cycle; m0_readdatavalid exactly 2 cycles after the read grant with data 32'hDEADBEEF.
- m0 and m1 both issue continuous reads from cycle 0 -> grants alternate m0, m1, m0, m1; each readdatavalid pulses on its own port only, in issue order, 2 cycles after its grant.
- m1 writes 32'h11223344 full, then byteenable 4'h2 with data 32'h0000AA00, then reads -> readdata 32'h1122AA44.
- m0 writes to 16'd40000, then reads 16'd40000 -> mem_chipselect stays 0; readdata 0 with valid at N+2; oor_count = 2. Force the count to saturate -> stays 16'hFFFF.
- m0 asserts read and write together to 16'h0005 -> performed as a write; no readdatavalid.
- m1 read granted, reset_n pulsed low in the next cycle -> no m1_readdatavalid; all outputs at reset values during reset; the first post-reset simultaneous request is granted to m0.
